// File: rtl/one_four_demux_buf_pkg.sv
// Shared types and constants for the buffered 1-to-4 demultiplexer.
package one_four_demux_buf_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   localparam int CNT_W  = 8;

   typedef logic [SEL_W-1:0]  ch_idx_t;
   typedef logic [NUM_CH-1:0] ch_mask_t;

   // Unicast steers to one channel; broadcast writes every channel at once.
   typedef enum logic {
      MODE_UNICAST = 1'b0,
      MODE_BCAST   = 1'b1
   } xfer_mode_e;

   // Plain binary channel index to one-hot mask: 0 -> 4'b0001 ... 3 -> 4'b1000.
   // Same select convention as the 4:1 operand-gather muxes.
   function automatic ch_mask_t ch_onehot(input ch_idx_t idx);
      ch_onehot = ch_mask_t'(1) << idx;
   endfunction

endpackage

// File: rtl/one_four_demux_buf_if.sv
// Producer/consumer bundle of the buffered 1-to-4 demultiplexer.
// The slave side is the demux itself; the master side drives the producer
// word and the consumer acks.
interface one_four_demux_buf_if
   import one_four_demux_buf_pkg::*;
#(
   parameter int WIDTH = 8
);

   // Producer side
   ch_idx_t            sel;
   logic               bcast;
   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;

   // Consumer side
   logic [WIDTH-1:0]   out_data0;
   logic [WIDTH-1:0]   out_data1;
   logic [WIDTH-1:0]   out_data2;
   logic [WIDTH-1:0]   out_data3;
   ch_mask_t           out_valid;
   ch_mask_t           out_ack;

   // Status
   logic [CNT_W-1:0]   accept_count;

   modport master (
      output sel, bcast, in_data, in_valid, out_ack,
      input  in_ready, out_data0, out_data1, out_data2, out_data3,
             out_valid, accept_count
   );

   modport slave (
      input  sel, bcast, in_data, in_valid, out_ack,
      output in_ready, out_data0, out_data1, out_data2, out_data3,
             out_valid, accept_count
   );

endinterface

// File: rtl/one_four_demux_buf_demux_slot.sv
// Demux slot: one channel's single-entry holding register with valid/ack.
// The slot is free when it is empty or being drained this cycle, so a load
// and an ack in the same cycle give one word per cycle of throughput.
module one_four_demux_buf_demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             ack,
   input  logic [WIDTH-1:0] d,
   output logic             free,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   assign free  = !valid_q | ack;
   assign valid = valid_q;
   assign q     = data_q;

   // Next state: a load wins over an ack; an ack on an empty slot changes nothing.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = d;
      end else if (ack) begin
         valid_d = 1'b0;
      end
   end

   // Slot register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: the data register is reset as well because consumers observe 0 after reset,
      // not just an invalid flag.
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/one_four_demux_buf.sv
// Buffered 1-to-4 demultiplexer: steers one producer stream to a single
// channel chosen by sel, or to all four channels when bcast is set. Each
// channel holds one word until its consumer acks it.
module one_four_demux_buf
   import one_four_demux_buf_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   one_four_demux_buf_if.slave bus
);

   xfer_mode_e        mode;
   ch_mask_t          dest_mask;
   ch_mask_t          free_vec;
   ch_mask_t          load_vec;
   ch_mask_t          valid_vec;
   logic [WIDTH-1:0]  slot_q [NUM_CH];
   logic              accept;
   logic [CNT_W-1:0]  count_q, count_d;

   // Destination decode: one-hot of sel for unicast, every channel for broadcast.
   always_comb begin
      mode      = bus.bcast ? MODE_BCAST : MODE_UNICAST;
      dest_mask = '0;
      case (mode)
         MODE_BCAST:   dest_mask = '1;
         MODE_UNICAST: dest_mask = ch_onehot(bus.sel);
         default:      dest_mask = '0;
      endcase
   end

   // Ready when every destination channel is free. Built only from sel, bcast
   // and the slot state, so there is no path from in_valid or in_data.
   assign bus.in_ready = &(free_vec | ~dest_mask);
   assign accept       = bus.in_valid & bus.in_ready;
   assign load_vec     = dest_mask & {NUM_CH{accept}};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      one_four_demux_buf_demux_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load_vec[i]),
         .ack   (bus.out_ack[i]),
         .d     (bus.in_data),
         .free  (free_vec[i]),
         .valid (valid_vec[i]),
         .q     (slot_q[i])
      );
   end

   assign bus.out_valid = valid_vec;
   assign bus.out_data0 = slot_q[0];
   assign bus.out_data1 = slot_q[1];
   assign bus.out_data2 = slot_q[2];
   assign bus.out_data3 = slot_q[3];

   // Accept counter next state: one per accepted transfer, broadcast counts once.
   always_comb begin
      count_d = count_q;
      if (accept) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Accept counter register, wraps modulo 256.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.accept_count = count_q;

endmodule
